wb_queue: RTL and testbench

Write-back queue feeding the single register-file write port (`RegWEn`/`rsW`/`dataW`) of the RISC-V core. It sits between long-latency producers (load unit, multi-cycle multiply/divide) and the register file. Results are accepted over a valid/ready handshake and buffered in an in-order FIFO. The FIFO drains into the register file on cycles where the main pipeline is not writing. Per-source pending flags are exported so decode can stall on read-after-write hazards.

---
 rtl/wb_queue.sv | 127 ++++++++++++
 tb/tb_wb_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: buffers long-latency results and drains them into the single
// register-file write port when the pipeline is idle. Optional macro: WBQ_BYPASS_EN.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [4:0]               req_addr_i,
  input  logic [DW-1:0]            req_data_i,
  input  logic                     pipe_wren_i,
  output logic                     RegWEn_o,
  output logic [4:0]               rsW_o,
  output logic [DW-1:0]            dataW_o,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  output logic                     rs1_pend_o,
  output logic                     rs2_pend_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [4:0]      mem_addr_r [DEPTH];
  logic [DW-1:0]   mem_data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;

  logic            empty_s;
  logic            full_s;
  logic            push_acc_s;
  logic            store_s;
  logic            pop_s;
  logic            byp_s;
  logic [AW-1:0]   wr_idx_s;
  logic [AW-1:0]   rd_idx_s;

  assign wr_idx_s   = wr_ptr_r[AW-1:0];
  assign rd_idx_s   = rd_ptr_r[AW-1:0];
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_idx_s == rd_idx_s);
  assign push_acc_s = req_valid_i && !full_s;
  assign pop_s      = !empty_s && !pipe_wren_i;

`ifdef WBQ_BYPASS_EN
  // An idle queue hands a fresh result straight to the write port.
  assign byp_s = empty_s && !pipe_wren_i && req_valid_i && (req_addr_i != 5'd0);
`else
  assign byp_s = 1'b0;
`endif

  // x0 results complete the handshake but are dropped.
  assign store_s = push_acc_s && (req_addr_i != 5'd0) && !byp_s;

  assign req_ready_o = !full_s;
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign count_o     = wr_ptr_r - rd_ptr_r;
  assign RegWEn_o    = pop_s || byp_s;

  // Pointer and valid-bit state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      valid_r  <= {DEPTH{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r          <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
        valid_r[wr_idx_s] <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r          <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        valid_r[rd_idx_s] <= 1'b0;
      end
    end
  end

  // Entry payload storage; contents are only observed through valid_r or the head.
  always_ff @(posedge clk_i) begin
    if (store_s) begin
      mem_addr_r[wr_idx_s] <= req_addr_i;
      mem_data_r[wr_idx_s] <= req_data_i;
    end
  end

  // Write-port mux: head entry, bypassed request, or zeros when idle.
  always_comb begin
    rsW_o   = 5'd0;
    dataW_o = {DW{1'b0}};
    if (pop_s) begin
      rsW_o   = mem_addr_r[rd_idx_s];
      dataW_o = mem_data_r[rd_idx_s];
    end else if (byp_s) begin
      rsW_o   = req_addr_i;
      dataW_o = req_data_i;
    end else begin
      rsW_o   = 5'd0;
      dataW_o = {DW{1'b0}};
    end
  end

  // Hazard flags over every occupied entry, including the head being written.
  always_comb begin
    rs1_pend_o = 1'b0;
    rs2_pend_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (rs1_i != 5'd0) && (mem_addr_r[i] == rs1_i)) begin
        rs1_pend_o = 1'b1;
      end else begin
        rs1_pend_o = rs1_pend_o;
      end
      if (valid_r[i] && (rs2_i != 5'd0) && (mem_addr_r[i] == rs2_i)) begin
        rs2_pend_o = 1'b1;
      end else begin
        rs2_pend_o = rs2_pend_o;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: queue-based reference model checked every cycle, plus directed
// literal expectations for each scenario.
`timescale 1ns/100ps
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_addr = 5'd0;
  logic [DW-1:0] req_data = 32'd0;
  logic          pipe_wren = 1'b0;
  logic          regwen;
  logic [4:0]    rsw;
  logic [DW-1:0] dataw;
  logic [4:0]    rs1 = 5'd0;
  logic [4:0]    rs2 = 5'd0;
  logic          rs1_pend, rs2_pend;
  logic [2:0]    count;
  logic          empty, full;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  logic [DW-1:0] rf [32];
  ent_t q [$];

  wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .pipe_wren_i(pipe_wren),
    .RegWEn_o(regwen), .rsW_o(rsw), .dataW_o(dataw),
    .rs1_i(rs1), .rs2_i(rs2),
    .rs1_pend_o(rs1_pend), .rs2_pend_o(rs2_pend),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_byp();
`ifdef WBQ_BYPASS_EN
    return (q.size() == 0) && !pipe_wren && req_valid && (req_addr != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_pend(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].a == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: one in-order queue updated from the inputs seen at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      automatic logic do_pop  = (q.size() > 0) && !pipe_wren;
      automatic logic do_push = req_valid && (q.size() < DEPTH) && (req_addr != 5'd0) && !model_byp();
      automatic ent_t e;
      e.a = req_addr;
      e.d = req_data;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      automatic int sz = q.size();
      automatic logic b = model_byp();
      automatic logic ew = b || ((sz > 0) && !pipe_wren);
      automatic logic [4:0] ea = 5'd0;
      automatic logic [DW-1:0] ed = 32'd0;
      if (ew && sz > 0) begin ea = q[0].a; ed = q[0].d; end
      else if (ew) begin ea = req_addr; ed = req_data; end
      chk("m_count", 64'(count), 64'(sz));
      chk("m_empty", 64'(empty), 64'(sz == 0));
      chk("m_full", 64'(full), 64'(sz == DEPTH));
      chk("m_ready", 64'(req_ready), 64'(sz < DEPTH));
      chk("m_regwen", 64'(regwen), 64'(ew));
      chk("m_rsw", 64'(rsw), 64'(ea));
      chk("m_dataw", 64'(dataw), 64'(ed));
      chk("m_pend1", 64'(rs1_pend), 64'(model_pend(rs1)));
      chk("m_pend2", 64'(rs2_pend), 64'(model_pend(rs2)));
      if (regwen) begin
        rf[rsw] = dataw;
        n_writes++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_addr = a; req_data = d;
    cyc();
    req_valid = 1'b0; req_addr = 5'd0; req_data = 32'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_regwen"}, 64'(regwen), 64'd0);
    chk({tag, "_rsw"}, 64'(rsw), 64'd0);
    chk({tag, "_dataw"}, 64'(dataw), 64'd0);
    chk({tag, "_pend1"}, 64'(rs1_pend), 64'd0);
    chk({tag, "_pend2"}, 64'(rs2_pend), 64'd0);
  endtask

  function automatic logic [DW-1:0] wdat(input int i);
    return 32'h5000_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  initial begin
    int w0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wsnap;
    cyc(); cyc();
    #2;
    rs1 = 5'd3; rs2 = 5'd3;
    chk_reset_vals("rst");
    rst = 1'b0;

    // Basic drain of x3
    cyc();
`ifdef WBQ_BYPASS_EN
    req_valid = 1'b1; req_addr = 5'd3; req_data = 32'h13579bdf;
    #2;
    chk("byp_wen", 64'(regwen), 64'd1);
    chk("byp_rsw", 64'(rsw), 64'd3);
    chk("byp_data", 64'(dataw), 64'h13579bdf);
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_pend", 64'(rs1_pend), 64'd0);
    cyc();
    req_valid = 1'b0; req_addr = 5'd0; req_data = 32'd0;
    #2;
    chk("byp_after_wen", 64'(regwen), 64'd0);
`else
    push(5'd3, 32'h13579bdf);
    #2;
    chk("drain_wen", 64'(regwen), 64'd1);
    chk("drain_rsw", 64'(rsw), 64'd3);
    chk("drain_data", 64'(dataw), 64'h13579bdf);
    chk("drain_pend", 64'(rs1_pend), 64'd1);
    cyc();
    #2;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_pend0", 64'(rs1_pend), 64'd0);
`endif

    // Full and backpressure
    pipe_wren = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(4 + i), 32'hA000_0000 + 32'(i));
    #2;
    chk("full_flag", 64'(full), 64'd1);
    chk("full_ready", 64'(req_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_wen", 64'(regwen), 64'd0);
    pipe_wren = 1'b0;
    req_valid = 1'b1; req_addr = 5'd8; req_data = 32'h88;
    #1;
    chk("full_pop_ready", 64'(req_ready), 64'd0);
    chk("full_pop_rsw", 64'(rsw), 64'd4);
    cyc();
    req_valid = 1'b0; req_addr = 5'd0; req_data = 32'd0;
    for (int k = 1; k < 4; k++) begin
      #2;
      chk("full_seq_rsw", 64'(rsw), 64'(4 + k));
      chk("full_seq_data", 64'(dataw), 64'(32'hA000_0000 + 32'(k)));
      cyc();
    end
    #2;
    chk("full_x8_dropped", 64'(empty), 64'd1);

    // Same-address ordering
    rs2 = 5'd4;
    pipe_wren = 1'b1;
    push(5'd4, 32'h1);
    push(5'd4, 32'hffff1357);
    #2;
    chk("same_count", 64'(count), 64'd2);
    chk("same_pend_a", 64'(rs2_pend), 64'd1);
    pipe_wren = 1'b0;
    #1;
    chk("same_first", 64'(dataw), 64'h1);
    cyc();
    #2;
    chk("same_second", 64'(dataw), 64'hffff1357);
    chk("same_pend_b", 64'(rs2_pend), 64'd1);
    cyc();
    #2;
    chk("same_pend_c", 64'(rs2_pend), 64'd0);
    chk("same_rf", 64'(rf[4]), 64'hffff1357);

    // x0 discard
    rs1 = 5'd0;
    req_valid = 1'b1; req_addr = 5'd0; req_data = 32'h246;
    #1;
    chk("x0_ready", 64'(req_ready), 64'd1);
    chk("x0_wen_a", 64'(regwen), 64'd0);
    cyc();
    req_valid = 1'b0; req_data = 32'd0;
    #2;
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_wen_b", 64'(regwen), 64'd0);
    chk("x0_pend", 64'(rs1_pend), 64'd0);

    // Wrap-around with steady-state push+pop at count 2
    rs1 = 5'd10; rs2 = 5'd17;
    pipe_wren = 1'b1;
    push(5'd8, wdat(0));
    push(5'd9, wdat(1));
    pipe_wren = 1'b0;
    for (int i = 2; i < 10; i++) begin
      req_valid = 1'b1; req_addr = 5'(8 + i); req_data = wdat(i);
      #1;
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_rsw", 64'(rsw), 64'(8 + i - 2));
      chk("wrap_data", 64'(dataw), 64'(wdat(i - 2)));
      cyc();
    end
    req_valid = 1'b0; req_addr = 5'd0; req_data = 32'd0;
    #2;
    chk("wrap_tail_a", 64'(rsw), 64'd16);
    cyc();
    #2;
    chk("wrap_tail_b", 64'(rsw), 64'd17);
    chk("wrap_tail_cnt", 64'(count), 64'd1);
    cyc();
    #2;
    chk("wrap_empty", 64'(empty), 64'd1);

    // Reset mid-operation
    rs1 = 5'd20; rs2 = 5'd22;
    pipe_wren = 1'b1;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    push(5'd22, 32'h22);
    #2;
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_pend", 64'(rs1_pend), 64'd1);
    rst = 1'b1;
    #1;
    rs1 = 5'd0; rs2 = 5'd0;
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    pipe_wren = 1'b0;
    wsnap = n_writes;
    repeat (3) cyc();
    chk("mid_no_writes", 64'(n_writes - wsnap), 64'd0);
    push(5'd9, 32'habc);
`ifndef WBQ_BYPASS_EN
    #2;
    chk("post_rst_wen", 64'(regwen), 64'd1);
    chk("post_rst_rsw", 64'(rsw), 64'd9);
    chk("post_rst_data", 64'(dataw), 64'habc);
`endif
    cyc();
    #2;
    chk("post_rst_rf", 64'(rf[9]), 64'habc);
    chk("post_rst_empty", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
